// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the IF/DM memory arbiter.
//   arb_state_e  - transaction phase of the shared memory port
//   arb_owner_e  - which requester owns the current transaction
//   XLEN_DEFAULT - default address/data width
package mem_arbiter_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: combinational owner selection for the memory arbiter.
// Data accesses win, except when a waiting fetch has already been passed
// over STARVE_MAX times in a row.
//   if_req     in  fetch request present
//   dm_req     in  data request present
//   starve_cnt in  consecutive data wins while a fetch was waiting
//   owner      out selected owner (only meaningful when a request exists)
module mem_arb_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             if_req,
    input  logic             dm_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_owner_e       owner
);

    logic w_starved;

    assign w_starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        owner = OWN_DM;
        if (if_req && (!dm_req || w_starved)) begin
            owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch (IF) and
// data (DM) ports of the pipeline. One transaction in flight at a time.
//   clk, rst_                 clock, asynchronous active-low reset
//   if_req_i/if_addr_i        fetch request and address
//   if_kill_i                 drop the response of the current fetch
//   if_gnt_o/if_rvalid_o/if_rdata_o   fetch grant, response, data
//   dm_req_i/dm_we_i/dm_be_i/dm_addr_i/dm_wdata_i   data request fields
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o   data grant, response (also write ack), data
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o   registered memory request
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i   memory accept, response, data
//   err_o                     sticky protocol error
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    input  logic              if_kill_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [XLEN/8-1:0] dm_be_i,
    input  logic [XLEN-1:0]   dm_addr_i,
    input  logic [XLEN-1:0]   dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [XLEN-1:0]   dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              err_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int BEW   = XLEN / 8;

    arb_state_e       r_state, w_state_next;
    arb_owner_e       r_owner, w_sel_owner;
    logic [CNT_W-1:0] r_starve_cnt, w_starve_next;
    logic             r_kill_pend;
    logic             r_err;
    logic             r_mem_we;
    logic [BEW-1:0]   r_mem_be;
    logic [XLEN-1:0]  r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;

    logic w_any_req, w_latch, w_own_if, w_owner_req, w_busy, w_resp, w_gnt;

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_sel (
        .if_req     (if_req_i),
        .dm_req     (dm_req_i),
        .starve_cnt (r_starve_cnt),
        .owner      (w_sel_owner)
    );

    assign w_any_req   = if_req_i | dm_req_i;
    assign w_latch     = (r_state == IDLE) && w_any_req;
    assign w_own_if    = (r_owner == OWN_IF);
    assign w_owner_req = w_own_if ? if_req_i : dm_req_i;
    assign w_busy      = (r_state != IDLE);
    assign w_gnt       = (r_state == WAIT_GNT) && mem_gnt_i;
    assign w_resp      = (r_state == WAIT_RESP) && mem_rvalid_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_any_req)    w_state_next = WAIT_GNT;
            WAIT_GNT:  if (mem_gnt_i)    w_state_next = WAIT_RESP;
            WAIT_RESP: if (mem_rvalid_i) w_state_next = IDLE;
            default:                     w_state_next = IDLE;
        endcase
    end

    // Counts data wins taken while a fetch was waiting; an IF win clears it.
    // A DM win with the counter already at STARVE_MAX cannot happen while
    // if_req_i is high, the guard only keeps the count saturating.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_latch) begin
            if (w_sel_owner == OWN_IF) begin
                w_starve_next = '0;
            end else if (if_req_i && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
                w_starve_next = r_starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // Request fields are captured only when a new transaction starts, so
    // the memory sees them from a register and they never change mid-flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_owner     <= OWN_IF;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_latch) begin
            r_owner <= w_sel_owner;
            if (w_sel_owner == OWN_IF) begin
                // Fetches are full-width reads.
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= if_addr_i;
                r_mem_wdata <= '0;
            end else begin
                r_mem_we    <= dm_we_i;
                r_mem_be    <= dm_be_i;
                r_mem_addr  <= dm_addr_i;
                r_mem_wdata <= dm_wdata_i;
            end
        end
    end

    // A killed fetch still runs to completion on the memory side; only its
    // response is hidden from the fetch stage.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_kill_pend <= 1'b0;
        end else if (w_resp) begin
            r_kill_pend <= 1'b0;
        end else if (if_kill_i && w_own_if && w_busy) begin
            r_kill_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_err <= 1'b0;
        end else if ((mem_rvalid_i && (r_state != WAIT_RESP)) ||
                     ((r_state == WAIT_GNT) && !w_owner_req)) begin
            r_err <= 1'b1;
        end
    end

    assign mem_req_o   = (r_state == WAIT_GNT);
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign err_o       = r_err;

    assign if_gnt_o    = w_gnt &  w_own_if;
    assign dm_gnt_o    = w_gnt & ~w_own_if;
    assign if_rvalid_o = w_resp &  w_own_if & ~r_kill_pend & ~if_kill_i;
    assign dm_rvalid_o = w_resp & ~w_own_if;
    assign if_rdata_o  = (w_busy &&  w_own_if) ? mem_rdata_i : '0;
    assign dm_rdata_o  = (w_busy && !w_own_if) ? mem_rdata_i : '0;

endmodule
